// File: rtl/debug_pkg.sv
// Shared types for the debug halt controller: FSM states, halt causes and the dcsr reset value.
package debug_pkg;

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DRAIN  = 3'd1,
        S_ENTER  = 3'd2,
        S_HALTED = 3'd3,
        S_RESUME = 3'd4,
        S_STEP   = 3'd5
    } dbg_state_e;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        STEP    = 2'b01,
        HALTREQ = 2'b10,
        EBREAK  = 2'b11
    } dsp_cause_e;

    localparam logic [31:0] DCSR_RESET = 32'h3;

endpackage

// File: rtl/debug_halt_ctrl_if.sv
// Bundle of Debug Module, pipeline and debug-CSR signals around the halt controller.
interface debug_halt_ctrl_if;

    logic       dm_haltreq;
    logic       dm_resumereq;
    logic       dm_ndmreset;
    logic       pipe_ebreak;
    logic       pipe_retire;
    logic       pipe_idle;
    logic       dcsr_step;
    logic       dcsr_ebreakm;

    logic       pipe_stall;
    logic       pipe_kill_ebreak;
    logic       dsp_reg_access;
    logic [1:0] dsp_cause;
    logic       dsp_status_reset;
    logic       dm_halted;
    logic       dm_resumeack;

    // slave: the halt controller itself; master: DM, pipeline and CSR block around it
    modport slave (
        input  dm_haltreq, dm_resumereq, dm_ndmreset,
        input  pipe_ebreak, pipe_retire, pipe_idle,
        input  dcsr_step, dcsr_ebreakm,
        output pipe_stall, pipe_kill_ebreak, dsp_reg_access, dsp_cause,
        output dsp_status_reset, dm_halted, dm_resumeack
    );

    modport master (
        output dm_haltreq, dm_resumereq, dm_ndmreset,
        output pipe_ebreak, pipe_retire, pipe_idle,
        output dcsr_step, dcsr_ebreakm,
        input  pipe_stall, pipe_kill_ebreak, dsp_reg_access, dsp_cause,
        input  dsp_status_reset, dm_halted, dm_resumeack
    );

endinterface

// File: rtl/debug_step_timer.sv
// Saturating cycle counter bounding how long a single-stepped instruction may take to retire.
module debug_step_timer #(
    parameter int MAX = 64,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != MAX_C)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign expired = (cnt_reg == MAX_C);

endmodule

// File: rtl/debug_halt_ctrl.sv
// Debug-mode entry/exit FSM: halts the core on haltreq, ebreak or single step, drains the pipe,
// lets the CSR block capture dpc/cause, and resumes on resumereq.
module debug_halt_ctrl
    import debug_pkg::*;
#(
    parameter int STEP_TIMEOUT = 64,
    parameter int CNT_W        = $clog2(STEP_TIMEOUT + 1)
) (
    input logic              clk_i,
    input logic              reset_i,
    debug_halt_ctrl_if.slave dbg
);

    dbg_state_e state_reg, state_next;
    dsp_cause_e cause_reg, cause_next;
    logic       ndm_reg;
    logic       status_reset_reg;
    logic       step_expired;
    logic       step_en;
    logic       ebreak_hit;
    logic       halt_survives;

    logic       stall;
    logic       kill_ebreak;
    logic       reg_access;
    dsp_cause_e cause_out;
    logic       halted;
    logic       resumeack;

    assign ebreak_hit    = dbg.pipe_ebreak & dbg.dcsr_ebreakm;
    assign step_en       = (state_reg == S_STEP);
    assign halt_survives = (state_reg == S_HALTED) || (state_reg == S_ENTER);

    debug_step_timer #(
        .MAX (STEP_TIMEOUT),
        .W   (CNT_W)
    ) u_step_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr     (~step_en),
        .en      (step_en),
        .expired (step_expired)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg        <= S_RUN;
            cause_reg        <= HOLD;
            ndm_reg          <= 1'b0;
            status_reset_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cause_reg        <= cause_next;
            ndm_reg          <= dbg.dm_ndmreset;
            status_reset_reg <= dbg.dm_ndmreset & ~ndm_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_RUN: begin
                if (ebreak_hit) begin
                    state_next = S_DRAIN;
                    cause_next = EBREAK;
                end else if (dbg.dm_haltreq) begin
                    state_next = S_DRAIN;
                    cause_next = HALTREQ;
                end
            end
            S_DRAIN:  if (dbg.pipe_idle) state_next = S_ENTER;
            S_ENTER:  state_next = S_HALTED;
            S_HALTED: if (dbg.dm_resumereq && !dbg.dm_haltreq) state_next = S_RESUME;
            S_RESUME: begin
                cause_next = HOLD;
                state_next = dbg.dcsr_step ? S_STEP : S_RUN;
            end
            S_STEP: begin
                if (ebreak_hit) begin
                    state_next = S_DRAIN;
                    cause_next = EBREAK;
                end else if (dbg.pipe_retire) begin
                    state_next = S_DRAIN;
                    cause_next = STEP;
                end else if (dbg.dm_haltreq) begin
                    state_next = S_DRAIN;
                    cause_next = HALTREQ;
                end else if (step_expired) begin
                    state_next = S_DRAIN;
                    cause_next = STEP;
                end
            end
            default: begin
                state_next = S_RUN;
                cause_next = HOLD;
            end
        endcase
        // A halted core stays halted across a non-debug reset of the rest of the system
        if (dbg.dm_ndmreset && !halt_survives) begin
            state_next = S_RUN;
            cause_next = HOLD;
        end
    end

    always_comb begin
        stall       = 1'b0;
        reg_access  = 1'b0;
        cause_out   = HOLD;
        halted      = 1'b0;
        resumeack   = 1'b0;
        kill_ebreak = 1'b0;
        case (state_reg)
            S_RUN, S_STEP: kill_ebreak = ebreak_hit & ~dbg.dm_ndmreset;
            S_DRAIN:       stall = 1'b1;
            S_ENTER: begin
                stall      = 1'b1;
                reg_access = 1'b1;
                cause_out  = cause_reg;
            end
            S_HALTED: begin
                stall      = 1'b1;
                reg_access = 1'b1;
                halted     = 1'b1;
            end
            S_RESUME:      resumeack = 1'b1;
            default:       stall = 1'b0;
        endcase
    end

    assign dbg.pipe_stall       = stall;
    assign dbg.pipe_kill_ebreak = kill_ebreak;
    assign dbg.dsp_reg_access   = reg_access;
    assign dbg.dsp_cause        = cause_out;
    assign dbg.dsp_status_reset = status_reset_reg;
    assign dbg.dm_halted        = halted;
    assign dbg.dm_resumeack     = resumeack;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Directed cycle-by-cycle vectors for debug_halt_ctrl, plus step-timeout and async-reset sequences.
module tb_debug_halt_ctrl;

    localparam logic [7:0] I_HR   = 8'h80;
    localparam logic [7:0] I_RR   = 8'h40;
    localparam logic [7:0] I_NDM  = 8'h20;
    localparam logic [7:0] I_EB   = 8'h10;
    localparam logic [7:0] I_RET  = 8'h08;
    localparam logic [7:0] I_IDLE = 8'h04;
    localparam logic [7:0] I_STEP = 8'h02;
    localparam logic [7:0] I_EBM  = 8'h01;

    localparam logic [7:0] O_STALL = 8'h80;
    localparam logic [7:0] O_KILL  = 8'h40;
    localparam logic [7:0] O_REG   = 8'h20;
    localparam logic [7:0] O_C01   = 8'h08;
    localparam logic [7:0] O_C10   = 8'h10;
    localparam logic [7:0] O_C11   = 8'h18;
    localparam logic [7:0] O_SRES  = 8'h04;
    localparam logic [7:0] O_HALT  = 8'h02;
    localparam logic [7:0] O_ACK   = 8'h01;

    localparam logic [7:0] O_HLT   = O_STALL | O_REG | O_HALT;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] vexp;
        string      name;
    } vec_t;

    logic clk_i;
    logic reset_i;
    int   tests;
    int   fails;
    vec_t tbl[$];

    debug_halt_ctrl_if ifc ();

    debug_halt_ctrl #(
        .STEP_TIMEOUT (4)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .dbg     (ifc.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] outs();
        return {ifc.pipe_stall, ifc.pipe_kill_ebreak, ifc.dsp_reg_access, ifc.dsp_cause,
                ifc.dsp_status_reset, ifc.dm_halted, ifc.dm_resumeack};
    endfunction

    task automatic drive(input logic [7:0] vin);
        {ifc.dm_haltreq, ifc.dm_resumereq, ifc.dm_ndmreset, ifc.pipe_ebreak,
         ifc.pipe_retire, ifc.pipe_idle, ifc.dcsr_step, ifc.dcsr_ebreakm} = vin;
    endtask

    task automatic check(input logic [7:0] vexp, input string nm);
        logic [7:0] got;
        got = outs();
        tests++;
        if (got !== vexp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, got, vexp);
        end else begin
            $display("[TB] %s ok: out=%b", nm, got);
        end
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, then advance past the next edge
    task automatic run_vec(input logic [7:0] vin, input logic [7:0] vexp, input string nm);
        drive(vin);
        #1;
        check(vexp, nm);
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input logic [7:0] vin, input logic [7:0] vexp, input string nm);
        vec_t v;
        v.vin  = vin;
        v.vexp = vexp;
        v.name = nm;
        tbl.push_back(v);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_i = 1'b0;
        drive(8'h00);

        add(I_HR,                 8'h00,                     "run_haltreq");
        add(I_HR,                 O_STALL,                   "drain1");
        add(8'h00,                O_STALL,                   "drain2");
        add(I_IDLE,               O_STALL,                   "drain_idle");
        add(8'h00,                O_STALL | O_REG | O_C10,   "enter_haltreq");
        add(8'h00,                O_HLT,                     "halted");
        add(I_HR | I_RR,          O_HLT,                     "hr_rr_no_resume");
        add(I_RR | I_STEP,        O_HLT,                     "halted_resumereq");
        add(I_STEP,               O_ACK,                     "resume_to_step");
        add(I_RET,                8'h00,                     "step_retire");
        add(I_IDLE,               O_STALL,                   "step_drain");
        add(8'h00,                O_STALL | O_REG | O_C01,   "enter_step");
        add(I_RR,                 O_HLT,                     "halted_again");
        add(8'h00,                O_ACK,                     "resume_to_run");
        add(I_EB,                 8'h00,                     "ebreak_m0");
        add(8'h00,                8'h00,                     "run_no_stall");
        add(I_EB | I_EBM | I_HR,  O_KILL,                    "ebreak_and_haltreq");
        add(I_IDLE,               O_STALL,                   "ebreak_drain");
        add(8'h00,                O_STALL | O_REG | O_C11,   "enter_ebreak");
        add(I_NDM,                O_HLT,                     "halted_ndm_rise");
        add(I_NDM,                O_HLT | O_SRES,            "halted_status_reset");
        add(8'h00,                O_HLT,                     "halt_survives_ndm");
        add(I_RR,                 O_HLT,                     "halted_resume3");
        add(8'h00,                O_ACK,                     "resume3");
        add(I_NDM,                8'h00,                     "run_ndm_rise");
        add(I_NDM,                O_SRES,                    "run_status_reset");
        add(I_HR,                 8'h00,                     "run_haltreq2");
        add(I_NDM,                O_STALL,                   "drain_ndm_rise");
        add(I_NDM,                O_SRES,                    "ndm_forces_run");
        add(8'h00,                8'h00,                     "run_after_ndm");

        repeat (3) @(posedge clk_i);
        #1;
        check(8'h00, "reset_state");
        #4 reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        foreach (tbl[i]) run_vec(tbl[i].vin, tbl[i].vexp, tbl[i].name);

        // Step without retire: timer reaches 4 on the fifth STEP cycle and forces the halt
        run_vec(I_HR,            8'h00,                   "t_haltreq");
        run_vec(I_IDLE,          O_STALL,                 "t_drain");
        run_vec(8'h00,           O_STALL | O_REG | O_C10, "t_enter");
        run_vec(I_RR | I_STEP,   O_HLT,                   "t_halted");
        run_vec(I_STEP,          O_ACK,                   "t_resume");
        for (int k = 1; k <= 5; k++) run_vec(8'h00, 8'h00, $sformatf("t_step_cycle%0d", k));
        run_vec(I_IDLE,          O_STALL,                 "t_timeout_drain");
        run_vec(8'h00,           O_STALL | O_REG | O_C01, "t_timeout_enter");

        // Async reset while stepping: back to RUN, so a later retire no longer halts
        run_vec(I_RR | I_STEP,   O_HLT,                   "r_halted");
        run_vec(I_STEP,          O_ACK,                   "r_resume");
        run_vec(8'h00,           8'h00,                   "r_step");
        reset_i = 1'b0;
        #1;
        check(8'h00, "reset_in_step");
        #3 reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_vec(I_RET,           8'h00,                   "r_retire_in_run");
        run_vec(8'h00,           8'h00,                   "r_no_drain");

        // Async reset mid-DRAIN releases the stall without waiting for a clock edge
        run_vec(I_HR,            8'h00,                   "r_haltreq");
        drive(8'h00);
        #1;
        check(O_STALL, "r_drain_stall");
        reset_i = 1'b0;
        #1;
        check(8'h00, "reset_in_drain");
        #2 reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_vec(8'h00,           8'h00,                   "r_released");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
